// File: rtl/spectag_manager_pkg.sv
// Shared constants for the speculative-tag manager.
//   SPECTAG_LEN_DEFAULT : one-hot speculative tag width, which is also the
//                         maximum number of branches in flight at once.
package spectag_manager_pkg;

    localparam int SPECTAG_LEN_DEFAULT = 5;

endpackage

// File: rtl/spectag_manager_if.sv
// Interface bundling the allocate (decode) and resolve (branch unit) sides
// of the speculative-tag manager, plus the status it publishes.
//   master : decode/branch-unit side; drives alloc_req and resolve_*.
//   slave  : the tag manager; drives grants, masks and status.
// Handshake: alloc_req/alloc_gnt is a same-cycle request/grant. A tag is
// consumed only in a cycle where both are high, and alloc_tag is meaningful
// only then. resolve_valid qualifies resolve_success/resolve_miss/resolve_tag
// for one cycle and has no backpressure.
interface spectag_manager_if
    import spectag_manager_pkg::*;
#(
    parameter int SPECTAG_LEN = SPECTAG_LEN_DEFAULT
);
    logic                   alloc_req;
    logic                   alloc_gnt;
    logic [SPECTAG_LEN-1:0] alloc_tag;
    logic                   alloc_specbit;
    logic                   resolve_valid;
    logic                   resolve_success;
    logic                   resolve_miss;
    logic [SPECTAG_LEN-1:0] resolve_tag;
    logic [SPECTAG_LEN-1:0] outstanding_mask;
    logic [SPECTAG_LEN-1:0] kill_mask;
    logic                   full;

    modport master (
        output alloc_req, resolve_valid, resolve_success, resolve_miss, resolve_tag,
        input  alloc_gnt, alloc_tag, alloc_specbit, outstanding_mask, kill_mask, full
    );

    modport slave (
        input  alloc_req, resolve_valid, resolve_success, resolve_miss, resolve_tag,
        output alloc_gnt, alloc_tag, alloc_specbit, outstanding_mask, kill_mask, full
    );
endinterface

// File: rtl/spectag_depmatrix.sv
// Dependency matrix for speculative tags. Row i holds the set of tags that
// were outstanding (older) when tag i was allocated.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears every row)
//   wr_sel      : one-hot row to load with wr_dep (all zero = no write)
//   wr_dep      : dependency set recorded for the newly granted tag
//   clr_col     : tag whose column is cleared in every row (resolved correctly)
//   clr_rows    : rows cleared outright (squashed tags)
//   query_tag   : one-hot tag of a mispredicted branch
//   live_mask   : currently outstanding tags
//   kill_set    : query_tag plus every live tag that depends on it
module spectag_depmatrix #(
    parameter int SPECTAG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SPECTAG_LEN-1:0] wr_sel,
    input  logic [SPECTAG_LEN-1:0] wr_dep,
    input  logic [SPECTAG_LEN-1:0] clr_col,
    input  logic [SPECTAG_LEN-1:0] clr_rows,
    input  logic [SPECTAG_LEN-1:0] query_tag,
    input  logic [SPECTAG_LEN-1:0] live_mask,
    output logic [SPECTAG_LEN-1:0] kill_set
);

    logic [SPECTAG_LEN-1:0] dep [SPECTAG_LEN];

    // Every tag younger than the mispredicted one recorded it as a
    // dependency at allocation, so a single column lookup finds them all.
    always_comb begin
        kill_set = query_tag;
        for (int i = 0; i < SPECTAG_LEN; i++) begin
            if (live_mask[i] && ((dep[i] & query_tag) != '0)) begin
                kill_set[i] = 1'b1;
            end
        end
    end

    // A written row belongs to a free tag, so it never overlaps clr_rows;
    // write still takes precedence so the fresh dependency set is kept intact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SPECTAG_LEN; i++) begin
            if (reset) begin
                dep[i] <= '0;
            end else if (wr_sel[i]) begin
                dep[i] <= wr_dep;
            end else if (clr_rows[i]) begin
                dep[i] <= '0;
            end else begin
                dep[i] <= dep[i] & ~clr_col;
            end
        end
    end

endmodule

// File: rtl/spectag_manager.sv
// Speculative branch tag manager. Hands out one-hot tags to branches at
// decode in round-robin order, tracks which are outstanding, and on a
// misprediction produces a one-cycle kill mask covering the mispredicted
// branch and everything younger.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; overrides alloc and resolve
//   bus   : spectag_manager_if slave modport (alloc, resolve, status)
module spectag_manager
    import spectag_manager_pkg::*;
#(
    parameter int SPECTAG_LEN = SPECTAG_LEN_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    spectag_manager_if.slave   bus
);

    logic [SPECTAG_LEN-1:0] ptr;
    logic [SPECTAG_LEN-1:0] outstanding;
    logic [SPECTAG_LEN-1:0] kill;

    logic [SPECTAG_LEN-1:0] ptr_next;
    logic [SPECTAG_LEN-1:0] outstanding_next;
    logic [SPECTAG_LEN-1:0] kill_next;

    logic                   full;
    logic                   gnt;
    logic                   resolve_ok;
    logic                   miss_acc;
    logic                   succ_acc;
    logic [SPECTAG_LEN-1:0] succ_free;
    logic [SPECTAG_LEN-1:0] kill_set;
    logic [SPECTAG_LEN-1:0] kill_now;

    // Full looks only at registered state: a tag freed this cycle becomes
    // grantable on the following cycle.
    assign full = |(ptr & outstanding);

    // A miss blocks allocation outright because the pointer is about to be
    // rewound to the mispredicted tag.
    assign gnt = bus.alloc_req & ~full & ~(bus.resolve_valid & bus.resolve_miss);

    // Resolves for tags not in flight, or with a malformed tag, are dropped.
    assign resolve_ok = bus.resolve_valid && $onehot(bus.resolve_tag)
                        && ((bus.resolve_tag & outstanding) != '0);
    // Miss wins when both outcome bits are set.
    assign miss_acc   = resolve_ok & bus.resolve_miss;
    assign succ_acc   = resolve_ok & ~bus.resolve_miss & bus.resolve_success;
    assign succ_free  = succ_acc ? bus.resolve_tag : '0;
    assign kill_now   = miss_acc ? kill_set : '0;

    spectag_depmatrix #(
        .SPECTAG_LEN (SPECTAG_LEN)
    ) u_depmatrix (
        .clk       (clk),
        .reset     (reset),
        .wr_sel    (gnt ? ptr : '0),
        .wr_dep    (outstanding & ~succ_free),
        .clr_col   (succ_free),
        .clr_rows  (kill_now),
        .query_tag (bus.resolve_tag),
        .live_mask (outstanding),
        .kill_set  (kill_set)
    );

    always_comb begin
        outstanding_next = outstanding & ~succ_free & ~kill_now;
        ptr_next         = ptr;
        kill_next        = kill_now;
        if (miss_acc) begin
            ptr_next = bus.resolve_tag;
        end else if (gnt) begin
            ptr_next = {ptr[SPECTAG_LEN-2:0], ptr[SPECTAG_LEN-1]};
        end
        if (gnt) begin
            outstanding_next = outstanding_next | ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= {{(SPECTAG_LEN-1){1'b0}}, 1'b1};
            outstanding <= '0;
            kill        <= '0;
        end else begin
            ptr         <= ptr_next;
            outstanding <= outstanding_next;
            kill        <= kill_next;
        end
    end

    assign bus.alloc_gnt        = gnt;
    assign bus.alloc_tag        = ptr;
    assign bus.alloc_specbit    = |outstanding;
    assign bus.outstanding_mask = outstanding;
    assign bus.kill_mask        = kill;
    assign bus.full             = full;

endmodule

// File: tb/tb_spectag_manager.sv
// Directed testbench for spectag_manager at SPECTAG_LEN=5.
module tb_spectag_manager;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [4:0] fill_seq [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};

    spectag_manager_if #(.SPECTAG_LEN(5)) bus ();

    spectag_manager #(.SPECTAG_LEN(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.alloc_req       = 1'b0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_success = 1'b0;
        bus.resolve_miss    = 1'b0;
        bus.resolve_tag     = 5'b00000;
    endtask

    task automatic drive_resolve(input logic [4:0] tag, input logic succ, input logic miss);
        bus.resolve_valid   = 1'b1;
        bus.resolve_success = succ;
        bus.resolve_miss    = miss;
        bus.resolve_tag     = tag;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        bus.alloc_req = 1'b1;
        repeat (n) tick();
        bus.alloc_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.alloc_req = 1'b1;
        drive_resolve(5'b00001, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        total++; if (bus.outstanding_mask !== 5'b00000) begin bad++; $display("FAIL reset_outstanding: got %b want 00000", bus.outstanding_mask); end
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL reset_kill: got %b want 00000", bus.kill_mask); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        total++; if (bus.alloc_specbit !== 1'b0) begin bad++; $display("FAIL reset_specbit: got %b want 0", bus.alloc_specbit); end
        total++; if (bus.alloc_tag !== 5'b00001) begin bad++; $display("FAIL reset_ptr: got %b want 00001", bus.alloc_tag); end
    endtask

    task automatic test_fill();
        bus.alloc_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bus.alloc_gnt !== 1'b1) begin bad++; $display("FAIL fill_gnt%0d: got %b want 1", i, bus.alloc_gnt); end
            total++; if (bus.alloc_tag !== fill_seq[i]) begin bad++; $display("FAIL fill_tag%0d: got %b want %b", i, bus.alloc_tag, fill_seq[i]); end
            tick();
        end
        #1;
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", bus.full); end
        total++; if (bus.alloc_gnt !== 1'b0) begin bad++; $display("FAIL fill_stall: got %b want 0", bus.alloc_gnt); end
        total++; if (bus.outstanding_mask !== 5'b11111) begin bad++; $display("FAIL fill_mask: got %b want 11111", bus.outstanding_mask); end
        total++; if (bus.alloc_specbit !== 1'b1) begin bad++; $display("FAIL fill_specbit: got %b want 1", bus.alloc_specbit); end
        tick();
        total++; if (bus.outstanding_mask !== 5'b11111) begin bad++; $display("FAIL fill_hold: got %b want 11111", bus.outstanding_mask); end
        bus.alloc_req = 1'b0;
        do_reset();
    endtask

    task automatic test_miss_younger();
        alloc_n(3);
        drive_resolve(5'b00010, 1'b0, 1'b1);
        tick();
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b00110) begin bad++; $display("FAIL miss_kill: got %b want 00110", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00001) begin bad++; $display("FAIL miss_mask: got %b want 00001", bus.outstanding_mask); end
        tick();
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL miss_kill_pulse: got %b want 00000", bus.kill_mask); end
        bus.alloc_req = 1'b1;
        #1;
        total++; if (bus.alloc_gnt !== 1'b1) begin bad++; $display("FAIL miss_regnt: got %b want 1", bus.alloc_gnt); end
        total++; if (bus.alloc_tag !== 5'b00010) begin bad++; $display("FAIL miss_retag: got %b want 00010", bus.alloc_tag); end
        tick();
        bus.alloc_req = 1'b0;
        total++; if (bus.outstanding_mask !== 5'b00011) begin bad++; $display("FAIL miss_realloc_mask: got %b want 00011", bus.outstanding_mask); end
        do_reset();
    endtask

    task automatic test_success_then_miss();
        alloc_n(3);
        drive_resolve(5'b00001, 1'b1, 1'b0);
        tick();
        idle_inputs();
        total++; if (bus.outstanding_mask !== 5'b00110) begin bad++; $display("FAIL succ_mask: got %b want 00110", bus.outstanding_mask); end
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL succ_nokill: got %b want 00000", bus.kill_mask); end
        total++; if (bus.alloc_tag !== 5'b01000) begin bad++; $display("FAIL succ_ptr: got %b want 01000", bus.alloc_tag); end
        drive_resolve(5'b00010, 1'b0, 1'b1);
        tick();
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b00110) begin bad++; $display("FAIL succmiss_kill: got %b want 00110", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00000) begin bad++; $display("FAIL succmiss_mask: got %b want 00000", bus.outstanding_mask); end
        do_reset();
    endtask

    task automatic test_same_cycle_miss();
        alloc_n(3);
        bus.alloc_req = 1'b1;
        drive_resolve(5'b00001, 1'b0, 1'b1);
        #1;
        total++; if (bus.alloc_gnt !== 1'b0) begin bad++; $display("FAIL samemiss_gnt: got %b want 0", bus.alloc_gnt); end
        tick();
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b00111) begin bad++; $display("FAIL samemiss_kill: got %b want 00111", bus.kill_mask); end
        total++; if (bus.alloc_tag !== 5'b00001) begin bad++; $display("FAIL samemiss_ptr: got %b want 00001", bus.alloc_tag); end
        total++; if (bus.outstanding_mask !== 5'b00000) begin bad++; $display("FAIL samemiss_mask: got %b want 00000", bus.outstanding_mask); end
        tick();
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL samemiss_pulse: got %b want 00000", bus.kill_mask); end
        do_reset();
    endtask

    task automatic test_wrap();
        alloc_n(5);
        bus.alloc_req = 1'b1;
        drive_resolve(5'b00001, 1'b1, 1'b0);
        #1;
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL wrap_full_same: got %b want 1", bus.full); end
        total++; if (bus.alloc_gnt !== 1'b0) begin bad++; $display("FAIL wrap_gnt_same: got %b want 0", bus.alloc_gnt); end
        tick();
        bus.resolve_valid = 1'b0;
        #1;
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL wrap_full_next: got %b want 0", bus.full); end
        total++; if (bus.alloc_gnt !== 1'b1) begin bad++; $display("FAIL wrap_gnt_next: got %b want 1", bus.alloc_gnt); end
        total++; if (bus.alloc_tag !== 5'b00001) begin bad++; $display("FAIL wrap_tag: got %b want 00001", bus.alloc_tag); end
        tick();
        idle_inputs();
        total++; if (bus.outstanding_mask !== 5'b11111) begin bad++; $display("FAIL wrap_mask: got %b want 11111", bus.outstanding_mask); end
        total++; if (bus.alloc_tag !== 5'b00010) begin bad++; $display("FAIL wrap_ptr: got %b want 00010", bus.alloc_tag); end
        // Re-allocated tag 00001 is younger than 00100, so a miss on 00100
        // squashes 00100, 01000, 10000 and the wrapped 00001.
        drive_resolve(5'b00100, 1'b0, 1'b1);
        tick();
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b11101) begin bad++; $display("FAIL wrap_kill: got %b want 11101", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00010) begin bad++; $display("FAIL wrap_kill_mask: got %b want 00010", bus.outstanding_mask); end
        total++; if (bus.alloc_tag !== 5'b00100) begin bad++; $display("FAIL wrap_kill_ptr: got %b want 00100", bus.alloc_tag); end
        do_reset();
    endtask

    task automatic test_ignored_resolve();
        alloc_n(2);
        drive_resolve(5'b01000, 1'b0, 1'b1);
        tick();
        total++; if (bus.outstanding_mask !== 5'b00011) begin bad++; $display("FAIL ign_free_mask: got %b want 00011", bus.outstanding_mask); end
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL ign_free_kill: got %b want 00000", bus.kill_mask); end
        total++; if (bus.alloc_tag !== 5'b00100) begin bad++; $display("FAIL ign_free_ptr: got %b want 00100", bus.alloc_tag); end
        drive_resolve(5'b00011, 1'b0, 1'b1);
        tick();
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL ign_multi_kill: got %b want 00000", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00011) begin bad++; $display("FAIL ign_multi_mask: got %b want 00011", bus.outstanding_mask); end
        drive_resolve(5'b00011, 1'b1, 1'b0);
        tick();
        total++; if (bus.outstanding_mask !== 5'b00011) begin bad++; $display("FAIL ign_succ_mask: got %b want 00011", bus.outstanding_mask); end
        // Both outcome bits set: handled as a miss.
        drive_resolve(5'b00010, 1'b1, 1'b1);
        tick();
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b00010) begin bad++; $display("FAIL both_kill: got %b want 00010", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00001) begin bad++; $display("FAIL both_mask: got %b want 00001", bus.outstanding_mask); end
        total++; if (bus.alloc_tag !== 5'b00010) begin bad++; $display("FAIL both_ptr: got %b want 00010", bus.alloc_tag); end
        do_reset();
    endtask

    task automatic test_success_with_grant();
        alloc_n(2);
        bus.alloc_req = 1'b1;
        drive_resolve(5'b00001, 1'b1, 1'b0);
        #1;
        total++; if (bus.alloc_gnt !== 1'b1) begin bad++; $display("FAIL sg_gnt: got %b want 1", bus.alloc_gnt); end
        total++; if (bus.alloc_tag !== 5'b00100) begin bad++; $display("FAIL sg_tag: got %b want 00100", bus.alloc_tag); end
        tick();
        idle_inputs();
        total++; if (bus.outstanding_mask !== 5'b00110) begin bad++; $display("FAIL sg_mask: got %b want 00110", bus.outstanding_mask); end
        total++; if (bus.alloc_tag !== 5'b01000) begin bad++; $display("FAIL sg_ptr: got %b want 01000", bus.alloc_tag); end
        drive_resolve(5'b00010, 1'b0, 1'b1);
        tick();
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b00110) begin bad++; $display("FAIL sg_kill: got %b want 00110", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00000) begin bad++; $display("FAIL sg_kill_mask: got %b want 00000", bus.outstanding_mask); end
        do_reset();
    endtask

    task automatic test_reset_priority();
        // Reset in the same cycle as the miss: no kill ever appears.
        alloc_n(3);
        reset = 1'b1;
        drive_resolve(5'b00010, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        idle_inputs();
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL rstmiss_kill: got %b want 00000", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00000) begin bad++; $display("FAIL rstmiss_mask: got %b want 00000", bus.outstanding_mask); end
        total++; if (bus.alloc_tag !== 5'b00001) begin bad++; $display("FAIL rstmiss_ptr: got %b want 00001", bus.alloc_tag); end
        // Reset the cycle after the miss: the pulse is cut to that one cycle.
        alloc_n(3);
        drive_resolve(5'b00010, 1'b0, 1'b1);
        tick();
        idle_inputs();
        reset = 1'b1;
        #1;
        total++; if (bus.kill_mask !== 5'b00110) begin bad++; $display("FAIL rstafter_pulse: got %b want 00110", bus.kill_mask); end
        tick();
        reset = 1'b0;
        total++; if (bus.kill_mask !== 5'b00000) begin bad++; $display("FAIL rstafter_kill: got %b want 00000", bus.kill_mask); end
        total++; if (bus.outstanding_mask !== 5'b00000) begin bad++; $display("FAIL rstafter_mask: got %b want 00000", bus.outstanding_mask); end
        bus.alloc_req = 1'b1;
        #1;
        total++; if (bus.alloc_gnt !== 1'b1) begin bad++; $display("FAIL rstafter_gnt: got %b want 1", bus.alloc_gnt); end
        total++; if (bus.alloc_tag !== 5'b00001) begin bad++; $display("FAIL rstafter_tag: got %b want 00001", bus.alloc_tag); end
        tick();
        bus.alloc_req = 1'b0;
        do_reset();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_fill();
        test_miss_younger();
        test_success_then_miss();
        test_same_cycle_miss();
        test_wrap();
        test_ignored_resolve();
        test_success_with_grant();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
